vend_change_dispenser: RTL
==========================

# vend_change_dispenser

Change pay-out controller for the vending machine. It runs the opposite direction to the coin-accumulation datapath: it takes an amount owed, in nickels, and returns it to the customer one coin at a time. Coins are chosen greedily, largest first (quarter, dime, nickel), and each coin is issued to the coin ejector over a req/ack handshake. The block sits between the vending controller, which starts it with the change amount, and the ejector mechanism.

## Interface
Parameters:
- `n`, 6, width of amount and remaining in nickels (max 2^n-1)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  load `amount` and begin pay-out; honoured only in IDLE
- `amount`  in  n  change owed, in nickels; sampled with `start`
- `abort`  in  1  stop pay-out after any coin currently being acknowledged
- `coin_req`  out  1  request to ejector to release one coin
- `coin_sel`  out  2  coin to release: 01 nickel, 10 dime, 11 quarter; 00 when idle
- `coin_ack`  in  1  ejector has released the requested coin; single-cycle pulse
- `busy`  out  1  pay-out in progress
- `done`  out  1  one-cycle pulse at end of pay-out
- `remaining`  out  n  nickels still owed
- `cnt_q`, `cnt_d`, `cnt_n`  out  4 each  quarters, dimes and nickels released since last `start`

## Operation
- Coin values in nickels are quarter=5, dime=2, nickel=1.
- Coin choice from `remaining`:
  - quarter if `remaining` >= 5
  - else dime if `remaining` >= 2
  - else nickel if `remaining` == 1
- States: IDLE, SEL, REQ, DONE.
- IDLE:
  - `busy`=0.
  - On `start`: `remaining` <= `amount`, all counts <= 0, go to SEL.
- SEL:
  - If `remaining`==0 or `abort`, go to DONE.
  - Otherwise register `coin_sel` from the greedy rule, set `coin_req` <= 1, go to REQ.
- REQ:
  - `coin_req`=1 and `coin_sel` are held stable until `coin_ack`.
  - On `coin_ack`: `remaining` -= coin value, the matching count increments, `coin_req` <= 0, `coin_sel` <= 00.
  - After the ack, go to DONE if `abort` is also high; otherwise go to SEL.
  - `abort` without `coin_ack`: drop `coin_req`, leave `remaining` unchanged, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in SEL, REQ and DONE.
- `start` is ignored outside IDLE, including in the DONE cycle.
- `coin_ack` is ignored outside REQ.
- Subtraction never underflows: the coin is always <= `remaining`.
- Count bound: greedy gives at most 12 quarters, 2 dimes and 1 nickel for n=6, so counts never wrap. No saturation logic is required.
- After DONE, `remaining` and the counts hold until the next `start`. A non-zero `remaining` after `done` means the pay-out was aborted.

## Timing
- Reset values: all outputs 0, state IDLE. `coin_req` drops asynchronously when `rst_n` falls, including mid-handshake; no coin is counted.
- `start` is sampled at edge 0 → SEL in cycle 1.
- Each coin takes SEL (1 cycle) plus REQ (1 cycle plus ack wait). With the ack in the first REQ cycle, that is 2 cycles per coin.
- With k coins and zero ack wait, DONE is in cycle 2+2k. For `amount`=0, DONE is in cycle 2.
- `coin_req` never stays high across an ack edge. There is at least one low cycle (SEL) between consecutive requests.
- Outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset, then `start` with `amount`=8 and immediate acks:
  - `coin_sel` sequence 11, 10, 01.
  - `remaining` 8→3→1→0.
  - `done` in cycle 8; counts q=1, d=1, n=1.
- `amount`=0:
  - No `coin_req`; `done` in cycle 2.
  - `busy` high in cycles 1–2; all counts 0.
- `amount`=63 with ack delayed 3 cycles per coin:
  - 12 quarters, 1 dime, 1 nickel, 14 coins total.
  - `coin_sel` stable while `coin_req` is high.
  - `remaining` ends at 0.
- `amount`=12, `abort` raised during the second quarter's REQ without ack:
  - `coin_req` drops.
  - `done` pulse; `remaining`=7; `cnt_q`=1.
  - `abort` together with `coin_ack` instead gives `remaining`=2, `cnt_q`=2.
- `start` pulsed while busy, and `coin_ack` pulsed in IDLE/SEL: both have no effect on state, `remaining` or counts.
- `rst_n` asserted mid-REQ: `coin_req` falls without waiting for a clock edge, all outputs 0; a new `start` then runs normally.

Source files
------------

// File: rtl/vend_change_dispenser_if.sv
// Controller/ejector-facing signal bundle for the change dispenser.
// The master side starts pay-out and acknowledges coins; the slave side is the dispenser.
interface vend_change_dispenser_if #(
    parameter int unsigned n = 6
);
    localparam int unsigned cnt_w = 4;

    logic             start;
    logic [n-1:0]     amount;
    logic             abort;
    logic             coin_req;
    logic [1:0]       coin_sel;
    logic             coin_ack;
    logic             busy;
    logic             done;
    logic [n-1:0]     remaining;
    logic [cnt_w-1:0] cnt_q;
    logic [cnt_w-1:0] cnt_d;
    logic [cnt_w-1:0] cnt_n;

    modport master (
        output start, amount, abort, coin_ack,
        input  coin_req, coin_sel, busy, done, remaining, cnt_q, cnt_d, cnt_n
    );

    modport slave (
        input  start, amount, abort, coin_ack,
        output coin_req, coin_sel, busy, done, remaining, cnt_q, cnt_d, cnt_n
    );
endinterface

// File: rtl/vend_change_dispenser.sv
// Change pay-out controller: returns an owed amount (in nickels) one coin at a time,
// largest coin first, over a req/ack handshake with the coin ejector.
module vend_change_dispenser #(
    parameter int unsigned n = 6
) (
    input logic                   clk,
    input logic                   rst_n,
    vend_change_dispenser_if.slave bus
);
    localparam int unsigned cnt_w = 4;

    localparam logic [1:0] sel_none    = 2'b00;
    localparam logic [1:0] sel_nickel  = 2'b01;
    localparam logic [1:0] sel_dime    = 2'b10;
    localparam logic [1:0] sel_quarter = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        REQ,
        DONE
    } state_t;

    state_t       state;
    logic [1:0]   pick_c;
    logic [n-1:0] coin_val_c;

    // Greedy choice from what is still owed
    always_comb begin
        pick_c = sel_none;
        if (bus.remaining >= n'(5)) begin
            pick_c = sel_quarter;
        end else if (bus.remaining >= n'(2)) begin
            pick_c = sel_dime;
        end else if (bus.remaining == n'(1)) begin
            pick_c = sel_nickel;
        end
    end

    // Value in nickels of the coin currently being requested
    always_comb begin
        coin_val_c = '0;
        case (bus.coin_sel)
            sel_quarter: coin_val_c = n'(5);
            sel_dime:    coin_val_c = n'(2);
            sel_nickel:  coin_val_c = n'(1);
            default:     coin_val_c = '0;
        endcase
    end

    // Reset clears coin_req asynchronously, abandoning any handshake in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.coin_req  <= 1'b0;
            bus.coin_sel  <= sel_none;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.remaining <= '0;
            bus.cnt_q     <= '0;
            bus.cnt_d     <= '0;
            bus.cnt_n     <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.remaining <= bus.amount;
                        bus.cnt_q     <= '0;
                        bus.cnt_d     <= '0;
                        bus.cnt_n     <= '0;
                        bus.busy      <= 1'b1;
                        state         <= SEL;
                    end
                end
                SEL: begin
                    if (bus.remaining == '0 || bus.abort) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        bus.coin_sel <= pick_c;
                        bus.coin_req <= 1'b1;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (bus.coin_ack) begin
                        bus.remaining <= bus.remaining - coin_val_c;
                        case (bus.coin_sel)
                            sel_quarter: bus.cnt_q <= bus.cnt_q + cnt_w'(1);
                            sel_dime:    bus.cnt_d <= bus.cnt_d + cnt_w'(1);
                            sel_nickel:  bus.cnt_n <= bus.cnt_n + cnt_w'(1);
                            default:     ;
                        endcase
                        bus.coin_req <= 1'b0;
                        bus.coin_sel <= sel_none;
                        if (bus.abort) begin
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= SEL;
                        end
                    end else if (bus.abort) begin
                        bus.coin_req <= 1'b0;
                        bus.coin_sel <= sel_none;
                        bus.done     <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
